// File: rtl/arbitro_botones.sv
// Button arbiter: short/long press detection per button, round-robin merge into an event FIFO.
// Optional auto-repeat of long events while held: define BOTON_REPEAT_EN.
module arbitro_botones #(
    parameter int N_BTN       = 4,
    parameter int LONG_TIME   = 25000000,
    parameter int REPEAT_TIME = 12500000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_in,
    input  logic                     evt_ready,
    input  logic                     clr_overflow,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic                     overflow,
    output logic                     busy
);
    localparam int IW = $clog2(N_BTN);
    localparam int CW = $clog2(LONG_TIME + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_TIME);
    localparam logic [CW-1:0] CNT_LONG = CW'(LONG_TIME - 2);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    if (N_BTN < 2 || N_BTN > 8 || LONG_TIME < 2 || REPEAT_TIME < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("arbitro_botones: unsupported parameter set");
    end

    logic [N_BTN-1:0] prev_q, prev_d, armed_q, armed_d, long_done_q, long_done_d;
    logic [N_BTN-1:0] short_pend_q, short_pend_d, long_pend_q, long_pend_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
`ifdef BOTON_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TIME + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TIME - 1);
    logic [RW-1:0]    rep_q [N_BTN];
    logic [RW-1:0]    rep_d [N_BTN];
`endif
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [IW:0]      mem_q [FIFO_DEPTH];
    logic [IW:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             evt_valid_q, evt_valid_d, evt_long_q, evt_long_d;
    logic [IW-1:0]    evt_id_q, evt_id_d;
    logic             overflow_q, overflow_d, busy_q, busy_d;

    logic             pop_s, load_s, full_s, push_s, drop_s;
    logic             gnt_found_s, gnt_long_s;
    logic [IW-1:0]    gnt_idx_s, cand_s;
    logic             set_short_s, set_long_s, clr_short_s, clr_long_s;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= N_BTN) begin
            t = t - N_BTN;
        end else begin
            t = t;
        end
        return t[IW-1:0];
    endfunction

    // Round-robin pick of one pending event, starting after the last granted button
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        gnt_long_s  = 1'b0;
        cand_s      = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            cand_s = rr_idx(last_grant_q, k);
            if (!gnt_found_s && (long_pend_q[cand_s] || short_pend_q[cand_s])) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
                gnt_long_s  = long_pend_q[cand_s];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // FIFO bookkeeping; the head slot is the registered output stage and counts toward occupancy
    always_comb begin
        pop_s     = evt_valid_q & evt_ready;
        full_s    = (mem_cnt_q + {{AW{1'b0}}, evt_valid_q}) == DEPTH_C;
        push_s    = gnt_found_s & (~full_s | pop_s);
        load_s    = (~evt_valid_q | pop_s) & (mem_cnt_q != '0);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {gnt_idx_s, gnt_long_s};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        mem_cnt_d = mem_cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, load_s};
        evt_id_d  = evt_id_q;
        evt_long_d = evt_long_q;
        if (load_s) begin
            evt_valid_d = 1'b1;
            {evt_id_d, evt_long_d} = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + AW'(1);
        end else if (pop_s) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
        last_grant_d = push_s ? gnt_idx_s : last_grant_q;
        busy_d       = |btn_in;
    end

    // Per-button press timing and pending-event bookkeeping
    always_comb begin
        prev_d       = btn_in;
        armed_d      = armed_q;
        long_done_d  = long_done_q;
        short_pend_d = short_pend_q;
        long_pend_d  = long_pend_q;
        cnt_d        = cnt_q;
`ifdef BOTON_REPEAT_EN
        rep_d        = rep_q;
`endif
        drop_s       = 1'b0;
        set_short_s  = 1'b0;
        set_long_s   = 1'b0;
        clr_short_s  = 1'b0;
        clr_long_s   = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            set_short_s = 1'b0;
            set_long_s  = 1'b0;
            if (btn_in[i] && !prev_q[i]) begin
                cnt_d[i]       = '0;
                armed_d[i]     = 1'b1;
                long_done_d[i] = 1'b0;
`ifdef BOTON_REPEAT_EN
                rep_d[i]       = '0;
`endif
            end else if (btn_in[i] && armed_q[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
                if (!long_done_q[i]) begin
                    // Fires on the hold cycle where the counter reaches LONG_TIME-1
                    if (cnt_q[i] == CNT_LONG) begin
                        set_long_s     = 1'b1;
                        long_done_d[i] = 1'b1;
`ifdef BOTON_REPEAT_EN
                        rep_d[i]       = '0;
`endif
                    end else begin
                        set_long_s = 1'b0;
                    end
                end else begin
`ifdef BOTON_REPEAT_EN
                    if (rep_q[i] == REP_LAST) begin
                        set_long_s = 1'b1;
                        rep_d[i]   = '0;
                    end else begin
                        rep_d[i]   = rep_q[i] + RW'(1);
                    end
`else
                    set_long_s = 1'b0;
`endif
                end
            end else if (!btn_in[i] && prev_q[i]) begin
                armed_d[i]  = 1'b0;
                set_short_s = armed_q[i] & ~long_done_q[i];
            end else begin
                armed_d[i] = armed_q[i];
            end
            clr_long_s  = push_s &  gnt_long_s & (gnt_idx_s == IW'(i));
            clr_short_s = push_s & ~gnt_long_s & (gnt_idx_s == IW'(i));
            drop_s = drop_s | (set_long_s  & long_pend_q[i]  & ~clr_long_s)
                            | (set_short_s & short_pend_q[i] & ~clr_short_s);
            long_pend_d[i]  = set_long_s  | (long_pend_q[i]  & ~clr_long_s);
            short_pend_d[i] = set_short_s | (short_pend_q[i] & ~clr_short_s);
        end
        overflow_d = drop_s | (overflow_q & ~clr_overflow);
    end

    // State registers; previous levels reset high so a button held through reset stays silent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '1;
            armed_q      <= '0;
            long_done_q  <= '0;
            short_pend_q <= '0;
            long_pend_q  <= '0;
            cnt_q        <= '{default: '0};
`ifdef BOTON_REPEAT_EN
            rep_q        <= '{default: '0};
`endif
            last_grant_q <= IW'(N_BTN - 1);
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_long_q   <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            armed_q      <= armed_d;
            long_done_q  <= long_done_d;
            short_pend_q <= short_pend_d;
            long_pend_q  <= long_pend_d;
            cnt_q        <= cnt_d;
`ifdef BOTON_REPEAT_EN
            rep_q        <= rep_d;
`endif
            last_grant_q <= last_grant_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_long_q   <= evt_long_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_long  = evt_long_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_arbitro_botones.sv
// Scoreboard bench for arbitro_botones with LONG_TIME=100, REPEAT_TIME=50, 4 buttons.
module tb_arbitro_botones;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_in = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid, evt_long, overflow, busy;
    logic [1:0] evt_id;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int exp_q[$];

    arbitro_botones #(
        .N_BTN(4), .LONG_TIME(100), .REPEAT_TIME(50), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .evt_ready(evt_ready),
        .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_long(evt_long), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int len);
        btn_in = btn_in | mask;
        tick(len);
        btn_in = btn_in & ~mask;
    endtask

    task automatic expect_evt(input int id, input int lng);
        exp_q.push_back(id * 2 + lng);
    endtask

    // Every accepted event is compared against the scoreboard head (encoded id*2+long)
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_evt", {29'd0, evt_id, evt_long}, -1);
            end else begin
                check_val("evt_id_long", {29'd0, evt_id, evt_long}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int pops0;
        int n_rep;
        // reset state
        tick(2);
        check_val("rst_valid", int'(evt_valid), 0);
        check_val("rst_id", int'(evt_id), 0);
        check_val("rst_long", int'(evt_long), 0);
        check_val("rst_ovf", int'(overflow), 0);
        check_val("rst_busy", int'(busy), 0);
        reset = 1'b0;
        evt_ready = 1'b1;
        tick(3);

        // short press on button 2, latency from release edge
        expect_evt(2, 0);
        btn_in[2] = 1'b1;
        tick(1);
        check_val("busy_on", int'(busy), 1);
        tick(9);
        btn_in[2] = 1'b0;
        tick(1);
        check_val("short_lat0", int'(evt_valid), 0);
        tick(1);
        check_val("short_lat1", int'(evt_valid), 0);
        check_val("busy_off", int'(busy), 0);
        tick(1);
        check_val("short_lat2", int'(evt_valid), 1);
        tick(5);
        check_val("short_drain", exp_q.size(), 0);

        // long press on button 1, no event on release
        expect_evt(1, 1);
        btn_in[1] = 1'b1;
        tick(101);
        check_val("long_early", int'(evt_valid), 0);
        tick(1);
        check_val("long_lat", int'(evt_valid), 1);
        tick(48);
        btn_in[1] = 1'b0;
        tick(10);
        check_val("long_drain", exp_q.size(), 0);

        // boundary: 99 cycles short, 100 cycles long
        expect_evt(3, 0);
        press(4'b1000, 99);
        tick(10);
        expect_evt(0, 1);
        press(4'b0001, 100);
        tick(10);
        check_val("bound_drain", exp_q.size(), 0);

        // simultaneous release after reset: ids in order 0..3
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        evt_ready = 1'b0;
        tick(1);
        expect_evt(0, 0); expect_evt(1, 0); expect_evt(2, 0); expect_evt(3, 0);
        press(4'b1111, 5);
        tick(8);
        check_val("rr_valid", int'(evt_valid), 1);
        check_val("rr_head", int'(evt_id), 0);
        tick(3);
        check_val("rr_stable", int'(evt_id), 0);
        evt_ready = 1'b1;
        tick(6);
        check_val("rr_empty_valid", int'(evt_valid), 0);
        check_val("rr_drain", exp_q.size(), 0);

        // overflow: FIFO full, button 0 twice
        evt_ready = 1'b0;
        expect_evt(0, 0); expect_evt(1, 0); expect_evt(2, 0); expect_evt(3, 0);
        press(4'b1111, 3);
        tick(8);
        expect_evt(0, 0);
        press(4'b0001, 3);
        tick(4);
        check_val("ovf_first", int'(overflow), 0);
        press(4'b0001, 3);
        tick(3);
        check_val("ovf_second", int'(overflow), 1);
        press(4'b0001, 3);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check_val("ovf_clr_vs_set", int'(overflow), 1);
        tick(2);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check_val("ovf_cleared", int'(overflow), 0);
        evt_ready = 1'b1;
        tick(15);
        check_val("ovf_drain", exp_q.size(), 0);
        check_val("ovf_empty_valid", int'(evt_valid), 0);

        // button held across reset release
        btn_in[1] = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        btn_in[1] = 1'b0;
        tick(10);
        check_val("held_rst_valid", int'(evt_valid), 0);
        check_val("held_rst_drain", exp_q.size(), 0);

        // reset with queued events
        evt_ready = 1'b0;
        expect_evt(0, 0); expect_evt(1, 0); expect_evt(2, 0);
        press(4'b0111, 3);
        tick(6);
        check_val("queued_valid", int'(evt_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_valid", int'(evt_valid), 0);
        check_val("async_rst_id", int'(evt_id), 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        evt_ready = 1'b1;
        tick(10);
        check_val("post_rst_valid", int'(evt_valid), 0);

        // long hold of 200 cycles: repeat events only when the option is built in
`ifdef BOTON_REPEAT_EN
        n_rep = 3;
`else
        n_rep = 1;
`endif
        for (int r = 0; r < n_rep; r++) expect_evt(2, 1);
        pops0 = n_pops;
        press(4'b0100, 200);
        tick(10);
        check_val("repeat_count", n_pops - pops0, n_rep);
        check_val("repeat_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arbitro_botones.md
ARBITRO_BOTONES -- requirements
Module: arbitro_botones

Interface
REQ-001 Parameter N_BTN, default 4: number of button channels, 2..8.
REQ-002 Parameter LONG_TIME, default 25000000: hold cycles that qualify a long press.
REQ-003 Parameter REPEAT_TIME, default 12500000: auto-repeat period in cycles, used only under REQ-026.
REQ-004 Parameter FIFO_DEPTH, default 4: event queue depth, power of two, >= 2.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 btn_in  in  N_BTN  debounced, synchronized button levels, 1 = pressed.
REQ-008 evt_ready  in  1  consumer accepts head event this cycle.
REQ-009 clr_overflow  in  1  one-cycle pulse clearing overflow.
REQ-010 evt_valid  out  1  queue non-empty; head event presented.
REQ-011 evt_id  out  clog2(N_BTN)  button index of head event.
REQ-012 evt_long  out  1  head event is long (1) or short (0).
REQ-013 overflow  out  1  sticky: an event was lost.
REQ-014 busy  out  1  OR of btn_in, registered.

Function
REQ-015 Per button: previous-level register, armed bit, long_done bit, hold counter of clog2(LONG_TIME+1) bits saturating at LONG_TIME.
REQ-016 Rising edge of btn_in[i]: counter cleared to 0, armed set, long_done cleared.
REQ-017 While btn_in[i] high and armed: counter increments each cycle; on the cycle it reaches LONG_TIME-1, long_pend[i] set, long_done set.
REQ-018 Falling edge with armed and !long_done: short_pend[i] set; armed cleared on every falling edge.
REQ-019 Falling edge with long_done: no short event; press of length exactly LONG_TIME-1 cycles is short, LONG_TIME cycles is long.
REQ-020 Event arriving while its pending bit already set: dropped, overflow set; set and clear of a pending bit in the same cycle: set wins, no drop.
REQ-021 Arbiter: each cycle at most one pending event pushed into FIFO, round-robin over buttons starting at last_grant+1; within one button long before short; pushed pending bit cleared same edge.
REQ-022 Push allowed when FIFO not full, or full with a pop in the same cycle; otherwise events stay pending (no loss).
REQ-023 Pop when evt_valid and evt_ready; evt_id/evt_long stable while evt_valid high and evt_ready low.
REQ-024 Latency, idle block: triggering edge sampled at clock edge N -> evt_valid high after edge N+2.
REQ-025 clr_overflow and a new overflow in the same cycle: overflow remains 1.

Configuration
REQ-026 Macro BOTON_REPEAT_EN defined: after long event, while still held, a further long event per button every REPEAT_TIME cycles (separate repeat counter); undefined: exactly one long event per press, no repeat counter synthesized.

Reset
REQ-027 Reset asserted: FIFO empty, all pending/armed/long_done/counters 0, last_grant = N_BTN-1, evt_valid 0, evt_id 0, evt_long 0, overflow 0, busy 0.
REQ-028 Previous-level registers reset to all ones: a button held through reset release produces no event until released and pressed again.
REQ-029 Reset mid-press or with queued events: all discarded, no event after release.

Verification
REQ-030 LONG_TIME=100, evt_ready=1: btn_in[2] high 10 cycles -> one event id=2 long=0, evt_valid 2 edges after release edge.
REQ-031 btn_in[1] high 150 cycles -> one event id=1 long=1 at hold cycle 100, none on release; 99-cycle press -> short, 100-cycle -> long.
REQ-032 Buttons 0..3 released same cycle, evt_ready=0 -> FIFO holds ids 0,1,2,3 in order; then ready=1 -> four pops, evt_valid drops.
REQ-033 evt_ready=0, FIFO full, button 0 pressed/released twice -> second short lost, overflow=1; clr_overflow -> overflow=0.
REQ-034 Button held across reset deassert then released -> no event; reset asserted with 3 queued events -> evt_valid=0 immediately.
REQ-035 BOTON_REPEAT_EN, REPEAT_TIME=50, hold 200 cycles -> long events at hold cycles 100, 150, 200; macro off -> one.
